// File: rtl/quantize_core_if.sv
// Operand/result handshake bundle for quantize_core; satFlag exists only when
// QUANTIZE_SAT_FLAG_EN is defined.
interface quantize_core_if #(
  parameter int OUT_W = 8
);
  logic             inValid;
  logic             inReady;
  logic [31:0]      inputFP;
  logic [31:0]      scale;
  logic             outValid;
  logic             outReady;
  logic [OUT_W-1:0] outputInt;
  logic [31:0]      scaledFp32;
`ifdef QUANTIZE_SAT_FLAG_EN
  logic             satFlag;
`endif

  modport master (
    output inValid,
    output inputFP,
    output scale,
    output outReady,
    input  inReady,
    input  outValid,
    input  outputInt,
    input  scaledFp32
`ifdef QUANTIZE_SAT_FLAG_EN
    , input satFlag
`endif
  );

  modport slave (
    input  inValid,
    input  inputFP,
    input  scale,
    input  outReady,
    output inReady,
    output outValid,
    output outputInt,
    output scaledFp32
`ifdef QUANTIZE_SAT_FLAG_EN
    , output satFlag
`endif
  );
endinterface

// File: rtl/quantize_core.sv
// Quantizes inputFP/scale to a saturated OUT_W-bit integer via a bit-serial fp32 divider.
// Define QUANTIZE_SAT_FLAG_EN to add the registered satFlag output.
module quantize_core #(
  parameter int OUT_W      = 8,
  parameter int ROUND_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  quantize_core_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  localparam logic [18:0]      MAG_POS = 19'((1 << (OUT_W - 1)) - 1);
  localparam logic [18:0]      MAG_NEG = 19'(1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0] POS_LIM = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_LIM = {1'b1, {(OUT_W - 1){1'b0}}};

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      aFp_q, aFp_d;
  logic [31:0]      bFp_q, bFp_d;
  logic [24:0]      rem_q, rem_d;
  logic [25:0]      quo_q, quo_d;
  logic [OUT_W-1:0] outInt_q, outInt_d;
  logic [31:0]      scaledFp_q, scaledFp_d;
  logic             outValid_q, outValid_d;
`ifdef QUANTIZE_SAT_FLAG_EN
  logic             satFlag_q, satFlag_d;
`endif

  logic [24:0]        divisor;
  logic               resSign;
  logic [7:0]         expA, expB;
  logic signed [10:0] expDiff, expRes;
  logic               normHi;
  logic [22:0]        resFrac;
  logic               aNan, bNan, aInf, bInf, aZero, bZero;

  assign divisor = {2'b01, bFp_q[22:0]};
  assign resSign = aFp_q[31] ^ bFp_q[31];
  assign expA    = aFp_q[30:23];
  assign expB    = bFp_q[30:23];
  assign expDiff = $signed({3'b000, expA}) - $signed({3'b000, expB});
  assign normHi  = quo_q[25];
  assign expRes  = expDiff + 11'sd127 - (normHi ? 11'sd0 : 11'sd1);
  assign resFrac = normHi ? quo_q[24:2] : quo_q[23:1];

  // Denormals are treated as zero on both operands.
  assign aNan  = (expA == 8'hFF) && (aFp_q[22:0] != 23'd0);
  assign bNan  = (expB == 8'hFF) && (bFp_q[22:0] != 23'd0);
  assign aInf  = (expA == 8'hFF) && (aFp_q[22:0] == 23'd0);
  assign bInf  = (expB == 8'hFF) && (bFp_q[22:0] == 23'd0);
  assign aZero = (expA == 8'h00);
  assign bZero = (expB == 8'h00);

  logic [31:0]      qExt, halfMask;
  logic [5:0]       shAmt;
  logic [18:0]      intMag, magRnd, magFinal, negMag;
  logic             halfBit, lowBits, roundUp, roundSat;
  logic [OUT_W-1:0] roundInt;
  logic [31:0]      roundFp;

  // Quotient value is quo_q * 2^(expDiff-25); shAmt drops the fractional bits.
  always_comb begin
    qExt     = {6'd0, quo_q};
    shAmt    = 6'(11'sd25 - expDiff);
    intMag   = 19'(qExt >> shAmt);
    halfMask = 32'd1 << (shAmt - 6'd1);
    halfBit  = |(qExt & halfMask);
    lowBits  = (|(qExt & (halfMask - 32'd1))) | (|rem_q);
    roundUp  = (ROUND_MODE == 0) && halfBit && (lowBits || intMag[0]);
    magRnd   = intMag + {18'd0, roundUp};
    magFinal = magRnd;
    roundSat = 1'b0;
    roundFp  = {resSign, expRes[7:0], resFrac};

    if (expDiff > 11'sd16) begin
      roundSat = 1'b1;
    end else if (expDiff < -11'sd2) begin
      magFinal = 19'd0;
    end else if (resSign ? (magRnd > MAG_NEG) : (magRnd > MAG_POS)) begin
      roundSat = 1'b1;
    end

    if (expRes > 11'sd254) begin
      roundFp  = {resSign, 8'hFF, 23'd0};
      roundSat = 1'b1;
    end else if (expRes < 11'sd1) begin
      roundFp  = {resSign, 31'd0};
    end

    if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
      roundFp  = 32'h7FC0_0000;
      magFinal = 19'd0;
      roundSat = 1'b0;
    end else if (aZero || bInf) begin
      roundFp  = {resSign, 31'd0};
      magFinal = 19'd0;
      roundSat = 1'b0;
    end else if (aInf || bZero) begin
      roundFp  = {resSign, 8'hFF, 23'd0};
      roundSat = 1'b1;
    end

    negMag = 19'd0 - magFinal;
    if (roundSat) begin
      roundInt = resSign ? NEG_LIM : POS_LIM;
    end else begin
      roundInt = resSign ? negMag[OUT_W-1:0] : magFinal[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.inValid) state_d = DIV;
      DIV:     if (cnt_q == 5'd25) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (bus.outReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Restoring division: one quotient bit per DIV cycle, integer bit first.
  always_comb begin
    aFp_d      = aFp_q;
    bFp_d      = bFp_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    outInt_d   = outInt_q;
    scaledFp_d = scaledFp_q;
    outValid_d = outValid_q;
`ifdef QUANTIZE_SAT_FLAG_EN
    satFlag_d  = satFlag_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.inValid) begin
          aFp_d = bus.inputFP;
          bFp_d = bus.scale;
          rem_d = {2'b01, bus.inputFP[22:0]};
          quo_d = 26'd0;
          cnt_d = 5'd0;
        end
      end
      DIV: begin
        if (rem_q >= divisor) begin
          rem_d = (rem_q - divisor) << 1;
          quo_d = {quo_q[24:0], 1'b1};
        end else begin
          rem_d = rem_q << 1;
          quo_d = {quo_q[24:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
      end
      ROUND: begin
        outInt_d   = roundInt;
        scaledFp_d = roundFp;
        outValid_d = 1'b1;
`ifdef QUANTIZE_SAT_FLAG_EN
        satFlag_d  = roundSat;
`endif
      end
      DONE: begin
        if (bus.outReady) outValid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      aFp_q      <= 32'd0;
      bFp_q      <= 32'd0;
      rem_q      <= 25'd0;
      quo_q      <= 26'd0;
      outInt_q   <= '0;
      scaledFp_q <= 32'd0;
      outValid_q <= 1'b0;
`ifdef QUANTIZE_SAT_FLAG_EN
      satFlag_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      aFp_q      <= aFp_d;
      bFp_q      <= bFp_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      outInt_q   <= outInt_d;
      scaledFp_q <= scaledFp_d;
      outValid_q <= outValid_d;
`ifdef QUANTIZE_SAT_FLAG_EN
      satFlag_q  <= satFlag_d;
`endif
    end
  end

  assign bus.inReady    = (state_q == IDLE);
  assign bus.outValid   = outValid_q;
  assign bus.outputInt  = outInt_q;
  assign bus.scaledFp32 = scaledFp_q;
`ifdef QUANTIZE_SAT_FLAG_EN
  assign bus.satFlag    = satFlag_q;
`endif

endmodule

// File: tb/tb_quantize_core.sv
// Directed bench for quantize_core: three instances (8-bit RNE, 8-bit truncate,
// 4-bit RNE) driven in lockstep from one vector table plus handshake/reset sequences.
module tb_quantize_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quantize_core_if #(.OUT_W(8)) if8 ();
  quantize_core_if #(.OUT_W(8)) ifT ();
  quantize_core_if #(.OUT_W(4)) if4 ();

  quantize_core #(.OUT_W(8), .ROUND_MODE(0)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  quantize_core #(.OUT_W(8), .ROUND_MODE(1)) dutT (.clk(clk), .rst(rst), .bus(ifT.slave));
  quantize_core #(.OUT_W(4), .ROUND_MODE(0)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expFp;
    logic [7:0]  expInt8;
    logic [7:0]  expIntT;
    logic [3:0]  expInt4;
    logic        expSat;
  } vec_t;

  vec_t vecs[21];
  int   nCompared   = 0;
  int   nMismatched = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setInputs(input logic v, input logic [31:0] a, input logic [31:0] b);
    if8.inValid = v; if8.inputFP = a; if8.scale = b;
    ifT.inValid = v; ifT.inputFP = a; ifT.scale = b;
    if4.inValid = v; if4.inputFP = a; if4.scale = b;
  endtask

  task automatic setOutReady(input logic r);
    if8.outReady = r;
    ifT.outReady = r;
    if4.outReady = r;
  endtask

  // Counts edges after the accepting edge until outValid is seen (bounded).
  task automatic waitOutValid(output int edges);
    edges = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      edges++;
      if (if8.outValid) break;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int lat);
    setInputs(1'b1, a, b);
    @(posedge clk); #1;
    setInputs(1'b0, a, b);
    waitOutValid(lat);
  endtask

  task automatic consume();
    setOutReady(1'b1);
    @(posedge clk); #1;
    setOutReady(1'b0);
  endtask

  task automatic checkOutput(input string tag, input vec_t v, input int lat);
    checkVal({tag, " latency"}, 32'(lat), 32'd27);
    checkVal({tag, " fp"}, if8.scaledFp32, v.expFp);
    checkVal({tag, " int8"}, {24'd0, if8.outputInt}, {24'd0, v.expInt8});
    checkVal({tag, " intTrunc"}, {24'd0, ifT.outputInt}, {24'd0, v.expIntT});
    checkVal({tag, " int4"}, {28'd0, if4.outputInt}, {28'd0, v.expInt4});
`ifdef QUANTIZE_SAT_FLAG_EN
    checkVal({tag, " satFlag"}, {31'd0, if8.satFlag}, {31'd0, v.expSat});
`endif
  endtask

  initial begin
    int   lat;
    logic sawValid;

    vecs[0]  = '{32'h40400000, 32'h40000000, 32'h3FC00000, 8'h02, 8'h01, 4'h2, 1'b0};
    vecs[1]  = '{32'h40200000, 32'h3F800000, 32'h40200000, 8'h02, 8'h02, 4'h2, 1'b0};
    vecs[2]  = '{32'hC0200000, 32'h3F800000, 32'hC0200000, 8'hFE, 8'hFE, 4'hE, 1'b0};
    vecs[3]  = '{32'h3FE00000, 32'h3F800000, 32'h3FE00000, 8'h02, 8'h01, 4'h2, 1'b0};
    vecs[4]  = '{32'h3F800000, 32'h3C000000, 32'h43000000, 8'h7F, 8'h7F, 4'h7, 1'b1};
    vecs[5]  = '{32'hBF800000, 32'h3C000000, 32'hC3000000, 8'h80, 8'h80, 4'h8, 1'b0};
    vecs[6]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 8'h7F, 8'h7F, 4'h7, 1'b1};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 8'h00, 8'h00, 4'h0, 1'b0};
    vecs[8]  = '{32'h40400000, 32'h3F800000, 32'h40400000, 8'h03, 8'h03, 4'h3, 1'b0};
    vecs[9]  = '{32'h41000000, 32'h3F800000, 32'h41000000, 8'h08, 8'h08, 4'h7, 1'b0};
    vecs[10] = '{32'h00000000, 32'h3F800000, 32'h00000000, 8'h00, 8'h00, 4'h0, 1'b0};
    vecs[11] = '{32'h80000000, 32'h3F800000, 32'h80000000, 8'h00, 8'h00, 4'h0, 1'b0};
    vecs[12] = '{32'h3E800000, 32'h3F800000, 32'h3E800000, 8'h00, 8'h00, 4'h0, 1'b0};
    vecs[13] = '{32'h3F400000, 32'h3F800000, 32'h3F400000, 8'h01, 8'h00, 4'h1, 1'b0};
    vecs[14] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 8'h00, 8'h00, 4'h0, 1'b0};
    vecs[15] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 8'h7F, 8'h7F, 4'h7, 1'b1};
    vecs[16] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 8'h80, 8'h80, 4'h8, 1'b1};
    vecs[17] = '{32'h42C80000, 32'h3F800000, 32'h42C80000, 8'h64, 8'h64, 4'h7, 1'b0};
    vecs[18] = '{32'hC3960000, 32'h3F800000, 32'hC3960000, 8'h80, 8'h80, 4'h8, 1'b1};
    vecs[19] = '{32'h42FB0000, 32'h3F800000, 32'h42FB0000, 8'h7E, 8'h7D, 4'h7, 1'b0};
    vecs[20] = '{32'h00400000, 32'h3F800000, 32'h00000000, 8'h00, 8'h00, 4'h0, 1'b0};

    rst = 1'b1;
    setInputs(1'b0, 32'd0, 32'd0);
    setOutReady(1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    checkVal("reset outValid", {31'd0, if8.outValid}, 32'd0);
    checkVal("reset inReady", {31'd0, if8.inReady}, 32'd1);
    checkVal("reset outputInt", {24'd0, if8.outputInt}, 32'd0);
    checkVal("reset scaledFp32", if8.scaledFp32, 32'd0);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("vec%0d", i), vecs[i], lat);
      consume();
    end

    // Stalled consumer: result held, second pair ignored until one edge after consumption.
    applyStimulus(32'h40400000, 32'h3F800000, lat);
    checkVal("hs first latency", 32'(lat), 32'd27);
    setInputs(1'b1, 32'h40200000, 32'h3F800000);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkVal($sformatf("hs hold%0d outValid", c), {31'd0, if8.outValid}, 32'd1);
      checkVal($sformatf("hs hold%0d int8", c), {24'd0, if8.outputInt}, 32'd3);
      checkVal($sformatf("hs hold%0d fp", c), if8.scaledFp32, 32'h40400000);
      checkVal($sformatf("hs hold%0d inReady", c), {31'd0, if8.inReady}, 32'd0);
    end
    consume();
    checkVal("hs consumed outValid", {31'd0, if8.outValid}, 32'd0);
    checkVal("hs consumed inReady", {31'd0, if8.inReady}, 32'd1);
    @(posedge clk); #1;
    checkVal("hs second accepted", {31'd0, if8.inReady}, 32'd0);
    setInputs(1'b0, 32'hC2C80000, 32'h3F000000);
    waitOutValid(lat);
    checkOutput("hs second", vecs[1], lat);
    consume();

    // Reset during DIV abandons the operation.
    setInputs(1'b1, 32'h40400000, 32'h40000000);
    @(posedge clk); #1;
    setInputs(1'b0, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkVal("rst mid outValid", {31'd0, if8.outValid}, 32'd0);
    checkVal("rst mid outputInt", {24'd0, if8.outputInt}, 32'd0);
    checkVal("rst mid scaledFp32", if8.scaledFp32, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkVal("rst release inReady", {31'd0, if8.inReady}, 32'd1);
    sawValid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (if8.outValid) sawValid = 1'b1;
    end
    checkVal("rst no late result", {31'd0, sawValid}, 32'd0);
    applyStimulus(vecs[3].a, vecs[3].b, lat);
    checkOutput("rst after", vecs[3], lat);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
